// File: rtl/ym_mix_sequencer.sv
// Time-multiplexed three-voice log-volume mixer for the Sunsoft 5B audio path.
// Optional per-voice muting is compiled in when YM_MIX_MUTE_EN is defined.
module ym_mix_sequencer #(
    parameter int PERIOD = 5,
    parameter int OUT_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mix_in,
    input  logic [4:0]       env_in,
    input  logic [4:0]       lvl0,
    input  logic [4:0]       lvl1,
    input  logic [4:0]       lvl2,
`ifdef YM_MIX_MUTE_EN
    input  logic [2:0]       mute_mask,
`endif
    output logic [OUT_W-1:0] audio_out,
    output logic             sample_stb
);

    localparam int P  = (PERIOD < 5) ? 5 : PERIOD;
    localparam int CW = $clog2(P);

    typedef enum logic [2:0] {SNAP, V0, V1, V2, OUT, IDLE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [OUT_W-1:0] acc;
    logic [2:0]      snap_gate;
    logic [4:0]      snap_env;
    logic [4:0]      snap_lvl0;
    logic [4:0]      snap_lvl1;
    logic [4:0]      snap_lvl2;

    logic [4:0]      lvl_sel;
    logic            voice_on;
    logic [4:0]      vsel;
    logic [7:0]      ylog;
    logic [10:0]     ylog_x5;

    function automatic logic [7:0] aylog(input logic [4:0] idx);
        case (idx)
            5'd0:  aylog = 8'd0;    5'd1:  aylog = 8'd1;
            5'd2:  aylog = 8'd2;    5'd3:  aylog = 8'd3;
            5'd4:  aylog = 8'd3;    5'd5:  aylog = 8'd4;
            5'd6:  aylog = 8'd5;    5'd7:  aylog = 8'd6;
            5'd8:  aylog = 8'd8;    5'd9:  aylog = 8'd9;
            5'd10: aylog = 8'd11;   5'd11: aylog = 8'd13;
            5'd12: aylog = 8'd16;   5'd13: aylog = 8'd18;
            5'd14: aylog = 8'd24;   5'd15: aylog = 8'd29;
            5'd16: aylog = 8'd32;   5'd17: aylog = 8'd34;
            5'd18: aylog = 8'd44;   5'd19: aylog = 8'd55;
            5'd20: aylog = 8'd61;   5'd21: aylog = 8'd66;
            5'd22: aylog = 8'd82;   5'd23: aylog = 8'd98;
            5'd24: aylog = 8'd114;  5'd25: aylog = 8'd130;
            5'd26: aylog = 8'd148;  5'd27: aylog = 8'd166;
            5'd28: aylog = 8'd187;  5'd29: aylog = 8'd207;
            5'd30: aylog = 8'd231;  default: aylog = 8'd255;
        endcase
    endfunction

    // One shared lookup: the current slot picks which voice feeds it.
    always_comb begin
        lvl_sel  = '0;
        voice_on = 1'b0;
        case (state)
            V0: begin lvl_sel = snap_lvl0; voice_on = snap_gate[0]; end
            V1: begin lvl_sel = snap_lvl1; voice_on = snap_gate[1]; end
            V2: begin lvl_sel = snap_lvl2; voice_on = snap_gate[2]; end
            default: begin lvl_sel = '0; voice_on = 1'b0; end
        endcase
        if (!voice_on)
            vsel = '0;
        else if (lvl_sel[4])
            vsel = snap_env;
        else
            vsel = {lvl_sel[3:0], 1'b0};
        ylog    = aylog(vsel);
        ylog_x5 = {1'b0, ylog, 2'b00} + {3'b000, ylog};
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= SNAP;
            cnt        <= '0;
            acc        <= '0;
            audio_out  <= '0;
            sample_stb <= 1'b0;
            snap_gate  <= '0;
            snap_env   <= '0;
            snap_lvl0  <= '0;
            snap_lvl1  <= '0;
            snap_lvl2  <= '0;
        end else begin
            sample_stb <= 1'b0;
            cnt        <= (cnt == CW'(P - 1)) ? '0 : cnt + CW'(1);
            case (state)
                SNAP: begin
`ifdef YM_MIX_MUTE_EN
                    snap_gate <= mix_in & ~mute_mask;
`else
                    snap_gate <= mix_in;
`endif
                    snap_env  <= env_in;
                    snap_lvl0 <= lvl0;
                    snap_lvl1 <= lvl1;
                    snap_lvl2 <= lvl2;
                    acc       <= '0;
                    state     <= V0;
                end
                V0: begin
                    acc   <= acc + OUT_W'(ylog_x5);
                    state <= V1;
                end
                V1: begin
                    acc   <= acc + OUT_W'(ylog_x5);
                    state <= V2;
                end
                V2: begin
                    acc   <= acc + OUT_W'(ylog_x5);
                    state <= OUT;
                end
                OUT: begin
                    audio_out  <= acc;
                    sample_stb <= 1'b1;
                    state      <= (P > 5) ? IDLE : SNAP;
                end
                IDLE: begin
                    state <= (cnt == CW'(P - 1)) ? SNAP : IDLE;
                end
                default: state <= SNAP;
            endcase
        end
    end

endmodule

// File: tb/tb_ym_mix_sequencer.sv
// Self-checking bench for ym_mix_sequencer: a per-sample arithmetic model of the mix,
// with edge-count bookkeeping for strobe timing, checked against PERIOD=5 and PERIOD=8 builds.
module tb_ym_mix_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mix_in = '0;
    logic [4:0]  env_in = '0;
    logic [4:0]  lvl0 = '0;
    logic [4:0]  lvl1 = '0;
    logic [4:0]  lvl2 = '0;
    logic [2:0]  mute_mask = '0;
    logic [11:0] audio_out;
    logic        sample_stb;
    logic [11:0] audio_out8;
    logic        sample_stb8;

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    int last_exp = 0;

`ifdef YM_MIX_MUTE_EN
    localparam bit HAS_MUTE = 1'b1;
`else
    localparam bit HAS_MUTE = 1'b0;
`endif

    int ay[32] = '{0, 1, 2, 3, 3, 4, 5, 6, 8, 9, 11, 13, 16, 18, 24, 29,
                   32, 34, 44, 55, 61, 66, 82, 98, 114, 130, 148, 166, 187, 207, 231, 255};

    ym_mix_sequencer #(.PERIOD(5), .OUT_W(12)) u_dut (
        .clk(clk), .reset(reset), .mix_in(mix_in), .env_in(env_in),
        .lvl0(lvl0), .lvl1(lvl1), .lvl2(lvl2),
`ifdef YM_MIX_MUTE_EN
        .mute_mask(mute_mask),
`endif
        .audio_out(audio_out), .sample_stb(sample_stb)
    );

    ym_mix_sequencer #(.PERIOD(8), .OUT_W(12)) u_dut8 (
        .clk(clk), .reset(reset), .mix_in(mix_in), .env_in(env_in),
        .lvl0(lvl0), .lvl1(lvl1), .lvl2(lvl2),
`ifdef YM_MIX_MUTE_EN
        .mute_mask(mute_mask),
`endif
        .audio_out(audio_out8), .sample_stb(sample_stb8)
    );

    always #5 clk = ~clk;

    // Falling edges seen since reset released; edge 1 is the first snapshot.
    always @(negedge clk) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    function automatic int model(input logic [2:0] m, input logic [4:0] e,
                                 input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] c, input logic [2:0] mu);
        int sum = 0;
        int idx;
        logic [4:0] lv;
        for (int v = 0; v < 3; v++) begin
            lv = (v == 0) ? a : (v == 1) ? b : c;
            if (lv >= 16) idx = e;
            else          idx = lv * 2;
            if (m[v] && !(HAS_MUTE && mu[v])) sum += 5 * ay[idx];
        end
        return sum;
    endfunction

    task automatic step;
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] m, input logic [4:0] e, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] c, input logic [2:0] mu);
        mix_in = m; env_in = e; lvl0 = a; lvl1 = b; lvl2 = c; mute_mask = mu;
    endtask

    task automatic scramble;
        drive(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom));
    endtask

    task automatic align(input string name);
        int guard = 0;
        while ((ecount % 5) != 0 && guard < 20) begin
            step;
            guard++;
        end
        if (guard >= 20) begin
            errors++;
            $display("FAIL %s align: ecount=%0d never reached a snapshot slot", name, ecount);
        end
    endtask

    // One full sample: inputs present at the snapshot edge, optionally disturbed afterwards.
    task automatic run_sample(input logic [2:0] m, input logic [4:0] e, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] c, input logic [2:0] mu,
                              input bit scr, input string name);
        int exp_v;
        align(name);
        drive(m, e, a, b, c, mu);
        exp_v = model(m, e, a, b, c, mu);
        for (int s = 0; s < 4; s++) begin
            step;
            checks++;
            if (sample_stb !== 1'b0 || audio_out !== 12'(last_exp)) begin
                errors++;
                $display("FAIL %s hold slot %0d: stb=%0b audio=%0d expected stb=0 audio=%0d",
                         name, s, sample_stb, audio_out, last_exp);
            end
            if (scr) scramble;
        end
        step;
        checks++;
        if (sample_stb !== 1'b1 || audio_out !== 12'(exp_v)) begin
            errors++;
            $display("FAIL %s out: stb=%0b audio=%0d expected stb=1 audio=%0d",
                     name, sample_stb, audio_out, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        scramble;
        repeat (3) step;
        checks++;
        if (audio_out !== 12'd0 || sample_stb !== 1'b0 || audio_out8 !== 12'd0 ||
            sample_stb8 !== 1'b0) begin
            errors++;
            $display("FAIL reset: audio=%0d stb=%0b audio8=%0d stb8=%0b expected all 0",
                     audio_out, sample_stb, audio_out8, sample_stb8);
        end
        last_exp = 0;
        reset = 1'b0;
    endtask

    task automatic test_vectors;
        run_sample(3'b001, 5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b000, 1'b0, "single_voice");
        run_sample(3'b111, 5'd31, 5'h10, 5'h10, 5'h10, 3'b000, 1'b0, "full_scale");
        run_sample(3'b111, 5'd0, 5'h01, 5'h08, 5'h00, 3'b000, 1'b0, "mixed_levels");
        run_sample(3'b000, 5'd31, 5'h1F, 5'h1F, 5'h1F, 3'b000, 1'b0, "all_gated");
        run_sample(3'b110, 5'd7, 5'h1F, 5'h13, 5'h0A, 3'b000, 1'b0, "env_mix");
    endtask

    task automatic test_snapshot;
        int exp_v;
        align("snapshot");
        drive(3'b111, 5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b000);
        exp_v = model(3'b111, 5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b000);
        step;
        lvl1 = 5'h00;
        repeat (4) step;
        checks++;
        if (sample_stb !== 1'b1 || audio_out !== 12'(exp_v)) begin
            errors++;
            $display("FAIL snapshot current: stb=%0b audio=%0d expected stb=1 audio=%0d",
                     sample_stb, audio_out, exp_v);
        end
        last_exp = exp_v;
        run_sample(3'b111, 5'd0, 5'h0F, 5'h00, 5'h0F, 3'b000, 1'b0, "snapshot_next");
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++)
            run_sample(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                       5'($urandom), 3'($urandom), 1'b1, "random");
    endtask

    task automatic test_reset_mid;
        int exp_v;
        run_sample(3'b111, 5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b000, 1'b0, "pre_reset");
        align("reset_mid");
        drive(3'b111, 5'd31, 5'h10, 5'h10, 5'h10, 3'b000);
        step;
        step;
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step;
            checks++;
            if (audio_out !== 12'd0 || sample_stb !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid %0d: audio=%0d stb=%0b expected audio=0 stb=0",
                         s, audio_out, sample_stb);
            end
        end
        reset = 1'b0;
        last_exp = 0;
        exp_v = model(3'b111, 5'd31, 5'h10, 5'h10, 5'h10, 3'b000);
        for (int n = 1; n <= 5; n++) begin
            step;
            checks++;
            if (sample_stb !== (n == 5) || audio_out !== 12'((n == 5) ? exp_v : 0)) begin
                errors++;
                $display("FAIL reset_release edge %0d: stb=%0b audio=%0d expected stb=%0b audio=%0d",
                         n, sample_stb, audio_out, (n == 5), (n == 5) ? exp_v : 0);
            end
        end
        last_exp = exp_v;
    endtask

    task automatic test_period8;
        int exp_v;
        bit want5;
        bit want8;
        reset = 1'b1;
        repeat (2) step;
        drive(3'b101, 5'd20, 5'h0F, 5'h04, 5'h13, 3'b000);
        exp_v = model(3'b101, 5'd20, 5'h0F, 5'h04, 5'h13, 3'b000);
        reset = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            step;
            want5 = (n >= 5) && ((n - 5) % 5 == 0);
            want8 = (n >= 5) && ((n - 5) % 8 == 0);
            checks++;
            if (sample_stb !== want5 || sample_stb8 !== want8) begin
                errors++;
                $display("FAIL period edge %0d: stb=%0b stb8=%0b expected stb=%0b stb8=%0b",
                         n, sample_stb, sample_stb8, want5, want8);
            end
            if (want8) begin
                checks++;
                if (audio_out8 !== 12'(exp_v)) begin
                    errors++;
                    $display("FAIL period8 audio edge %0d: audio8=%0d expected %0d",
                             n, audio_out8, exp_v);
                end
            end
        end
        last_exp = exp_v;
    endtask

`ifdef YM_MIX_MUTE_EN
    task automatic test_mute;
        run_sample(3'b111, 5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b010, 1'b0, "mute_mid");
        run_sample(3'b111, 5'd31, 5'h10, 5'h10, 5'h10, 3'b101, 1'b1, "mute_outer");
    endtask
`endif

    initial begin
        test_reset;
        test_vectors;
        test_snapshot;
        test_random;
        test_reset_mid;
        test_period8;
`ifdef YM_MIX_MUTE_EN
        test_mute;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
